rom_fetch: RTL and testbench



---
 rtl/rom_fetch.sv | 80 ++++++++
 tb/tb_rom_fetch.sv | 347 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rom_fetch.sv
// rom_fetch: burst reader for a combinational ROM with programmable access wait and FWFT output FIFO.
// Ports: fclk/rst clock and sync reset; req_* burst request (addr, len 0=256) with valid/ready;
// rom_addr/rom_data ROM port; out_* FIFO head stream with last flag; busy while fetching; sum of burst bytes.
module rom_fetch #(
    parameter int WAIT  = 2,
    parameter int DEPTH = 4
) (
    input  logic        fclk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [18:0] req_addr,
    input  logic [7:0]  req_len,
    output logic [18:0] rom_addr,
    input  logic [7:0]  rom_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [7:0]  out_data,
    output logic        out_last,
    output logic        busy,
    output logic [15:0] sum
);
    localparam int AW = $clog2(DEPTH);
    typedef enum logic {IDLE, FETCH} state_t;
    state_t state, state_nx;
    logic [3:0] wcnt;
    logic [8:0] left;
    logic [AW:0] wptr, rptr;
    logic [8:0] mem [DEPTH];
    logic accept, full, push, pop;
    // Full when pointers differ only in the wrap bit; evaluated before this edge's pop.
    assign full = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    always_ff @(posedge fclk) begin
        state <= rst ? IDLE : state_nx;
    end
    always_comb begin
        state_nx = accept ? FETCH : (push && left == 9'd1) ? IDLE : state;
    end
    always_comb begin
        req_ready = state == IDLE;
        busy      = state == FETCH;
        accept    = req_valid && req_ready;
        push      = busy && wcnt == 4'd0 && !full;
        out_valid = wptr != rptr;
        pop       = out_valid && out_ready;
        // Head is forced to zero when empty so outputs are clean out of reset.
        {out_last, out_data} = out_valid ? mem[rptr[AW-1:0]] : 9'd0;
    end
    always_ff @(posedge fclk) begin
        if (rst) begin
            rom_addr <= '0;
            wcnt     <= '0;
            left     <= '0;
            sum      <= '0;
            wptr     <= '0;
            rptr     <= '0;
        end else begin
            if (accept) begin
                rom_addr <= req_addr;
                left     <= req_len == 8'd0 ? 9'd256 : {1'b0, req_len};
                wcnt     <= 4'(WAIT);
                sum      <= '0;
            end else if (busy && wcnt != 4'd0) begin
                wcnt <= wcnt - 1'b1;
            end else if (push) begin
                sum <= sum + {8'd0, rom_data};
                if (left != 9'd1) begin
                    rom_addr <= rom_addr + 1'b1;
                    left     <= left - 1'b1;
                    wcnt     <= 4'(WAIT);
                end
            end
            if (push) begin
                mem[wptr[AW-1:0]] <= {left == 9'd1, rom_data};
                wptr <= wptr + 1'b1;
            end
            if (pop) rptr <= rptr + 1'b1;
        end
    end
endmodule

// File: tb/tb_rom_fetch.sv
// tb_rom_fetch: randomized scoreboard bench for rom_fetch (WAIT=2 and WAIT=0 instances).
module tb_rom_fetch;
    localparam int W = 2;
    logic fclk = 0, rst = 1;
    logic req_valid = 0, req_ready, out_valid, out_ready = 0, out_last, busy;
    logic [18:0] req_addr = 0, rom_addr;
    logic [7:0] req_len = 0, rom_data, out_data;
    logic [15:0] sum;
    logic req_valid0 = 0, req_ready0, out_valid0, out_ready0 = 0, out_last0, busy0;
    logic [18:0] req_addr0 = 0, rom_addr0;
    logic [7:0] req_len0 = 0, rom_data0, out_data0;
    logic [15:0] sum0;
    logic scramble = 0;
    int errors = 0, checks = 0, cyc = 0;
    logic [8:0] q[$], q0[$];
    logic [8:0] e, e0, hold_v, hold_v0;
    logic held = 0, held0 = 0, rand_rdy = 0, rand_rdy0 = 0;
    logic [15:0] exp_sum = 0, exp_sum0 = 0;

    rom_fetch #(.WAIT(W), .DEPTH(4)) dut (
        .fclk(fclk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_addr(req_addr), .req_len(req_len), .rom_addr(rom_addr), .rom_data(rom_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
        .busy(busy), .sum(sum)
    );
    rom_fetch #(.WAIT(0), .DEPTH(4)) dut0 (
        .fclk(fclk), .rst(rst), .req_valid(req_valid0), .req_ready(req_ready0),
        .req_addr(req_addr0), .req_len(req_len0), .rom_addr(rom_addr0), .rom_data(rom_data0),
        .out_valid(out_valid0), .out_ready(out_ready0), .out_data(out_data0), .out_last(out_last0),
        .busy(busy0), .sum(sum0)
    );

    always #5 fclk = ~fclk;
    always @(posedge fclk) cyc <= cyc + 1;

    function automatic logic [7:0] rom_byte(input logic [18:0] a);
        return scramble ? (a[7:0] ^ a[15:8] ^ 8'h5A) : a[7:0];
    endfunction
    assign rom_data  = scramble ? (rom_addr[7:0] ^ rom_addr[15:8] ^ 8'h5A) : rom_addr[7:0];
    assign rom_data0 = scramble ? (rom_addr0[7:0] ^ rom_addr0[15:8] ^ 8'h5A) : rom_addr0[7:0];

    always @(negedge fclk) begin
        if (held && out_valid) begin
            checks++;
            if ({out_last, out_data} !== hold_v) begin
                errors++;
                $display("FAIL hold_stable: got %h want %h", {out_last, out_data}, hold_v);
            end
        end
        held = out_valid && !out_ready;
        hold_v = {out_last, out_data};
        if (out_valid && out_ready) begin
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL stream: unexpected byte %h (last=%b), nothing expected", out_data, out_last);
            end else begin
                e = q.pop_front();
                if ({out_last, out_data} !== e) begin
                    errors++;
                    $display("FAIL stream: got last=%b data=%h want last=%b data=%h", out_last, out_data, e[8], e[7:0]);
                end
            end
        end
    end

    always @(negedge fclk) begin
        if (held0 && out_valid0) begin
            checks++;
            if ({out_last0, out_data0} !== hold_v0) begin
                errors++;
                $display("FAIL hold_stable0: got %h want %h", {out_last0, out_data0}, hold_v0);
            end
        end
        held0 = out_valid0 && !out_ready0;
        hold_v0 = {out_last0, out_data0};
        if (out_valid0 && out_ready0) begin
            checks++;
            if (q0.size() == 0) begin
                errors++;
                $display("FAIL stream0: unexpected byte %h (last=%b), nothing expected", out_data0, out_last0);
            end else begin
                e0 = q0.pop_front();
                if ({out_last0, out_data0} !== e0) begin
                    errors++;
                    $display("FAIL stream0: got last=%b data=%h want last=%b data=%h", out_last0, out_data0, e0[8], e0[7:0]);
                end
            end
        end
    end

    task automatic tick;
        @(posedge fclk);
        #1;
        if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
        if (rand_rdy0) out_ready0 = 1'($urandom_range(0, 1));
    endtask

    task automatic send(input logic [18:0] a, input logic [7:0] l);
        int t = 0;
        int n = (l == 8'd0) ? 256 : int'(l);
        while (!req_ready && t < 3000) begin tick; t++; end
        req_addr = a;
        req_len = l;
        req_valid = 1;
        tick;
        req_valid = 0;
        exp_sum = 0;
        for (int i = 0; i < n; i++) begin
            q.push_back({i == n - 1, rom_byte(a + 19'(i))});
            exp_sum += {8'd0, rom_byte(a + 19'(i))};
        end
    endtask

    task automatic send0(input logic [18:0] a, input logic [7:0] l);
        int t = 0;
        int n = (l == 8'd0) ? 256 : int'(l);
        while (!req_ready0 && t < 3000) begin tick; t++; end
        req_addr0 = a;
        req_len0 = l;
        req_valid0 = 1;
        tick;
        req_valid0 = 0;
        exp_sum0 = 0;
        for (int i = 0; i < n; i++) begin
            q0.push_back({i == n - 1, rom_byte(a + 19'(i))});
            exp_sum0 += {8'd0, rom_byte(a + 19'(i))};
        end
    endtask

    task automatic wait_drain(input int max);
        int t = 0;
        while ((q.size() != 0 || busy || out_valid) && t < max) begin tick; t++; end
    endtask

    task automatic wait_drain0(input int max);
        int t = 0;
        while ((q0.size() != 0 || busy0 || out_valid0) && t < max) begin tick; t++; end
    endtask

    task automatic test_reset;
        rst = 1;
        repeat (3) tick;
        checks += 10;
        if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready: got %b want 1", req_ready); end
        if (rom_addr !== 19'd0) begin errors++; $display("FAIL reset_rom_addr: got %h want 0", rom_addr); end
        if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        if (out_data !== 8'd0) begin errors++; $display("FAIL reset_out_data: got %h want 0", out_data); end
        if (out_last !== 1'b0) begin errors++; $display("FAIL reset_out_last: got %b want 0", out_last); end
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        if (sum !== 16'd0) begin errors++; $display("FAIL reset_sum: got %h want 0", sum); end
        if (req_ready0 !== 1'b1) begin errors++; $display("FAIL reset_req_ready0: got %b want 1", req_ready0); end
        if (out_valid0 !== 1'b0) begin errors++; $display("FAIL reset_out_valid0: got %b want 0", out_valid0); end
        if (rom_addr0 !== 19'd0) begin errors++; $display("FAIL reset_rom_addr0: got %h want 0", rom_addr0); end
        rst = 0;
        tick;
    endtask

    task automatic test_basic;
        scramble = 0;
        out_ready = 1;
        send(19'h00010, 8'd3);
        for (int k = 1; k <= 12; k++) begin
            tick;
            checks += 2;
            if (out_valid !== (k % (W + 1) == 0 && k <= 3 * (W + 1))) begin
                errors++;
                $display("FAIL basic_valid: cycle %0d got %b", k, out_valid);
            end
            if (req_ready !== (k >= 3 * (W + 1))) begin
                errors++;
                $display("FAIL basic_req_ready: cycle %0d got %b", k, req_ready);
            end
        end
        checks += 2;
        if (sum !== 16'h0033) begin errors++; $display("FAIL basic_sum: got %h want 0033", sum); end
        if (q.size() != 0) begin errors++; $display("FAIL basic_count: %0d bytes missing, want 0", q.size()); end
    endtask

    task automatic test_wrap;
        logic [18:0] ea;
        out_ready = 1;
        send(19'h7FFFE, 8'd4);
        for (int k = 0; k <= 14; k++) begin
            if (k > 0) tick;
            ea = 19'h7FFFE + 19'((k / (W + 1)) < 3 ? k / (W + 1) : 3);
            checks++;
            if (rom_addr !== ea) begin
                errors++;
                $display("FAIL wrap_addr: cycle %0d got %h want %h", k, rom_addr, ea);
            end
        end
        checks += 2;
        if (sum !== 16'h01FE) begin errors++; $display("FAIL wrap_sum: got %h want 01fe", sum); end
        if (q.size() != 0) begin errors++; $display("FAIL wrap_count: %0d bytes missing, want 0", q.size()); end
    endtask

    task automatic test_backpressure;
        logic [18:0] a = 19'h01230;
        out_ready = 0;
        send(a, 8'd6);
        repeat (25) tick;
        checks += 5;
        if (rom_addr !== a + 19'd4) begin errors++; $display("FAIL bp_addr: got %h want %h", rom_addr, a + 19'd4); end
        if (busy !== 1'b1) begin errors++; $display("FAIL bp_busy: got %b want 1", busy); end
        if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_valid: got %b want 1", out_valid); end
        if (out_data !== rom_byte(a)) begin errors++; $display("FAIL bp_head: got %h want %h", out_data, rom_byte(a)); end
        if (out_last !== 1'b0) begin errors++; $display("FAIL bp_head_last: got %b want 0", out_last); end
        out_ready = 1;
        wait_drain(200);
        checks += 3;
        if (q.size() != 0) begin errors++; $display("FAIL bp_count: %0d bytes missing, want 0", q.size()); end
        if (sum !== exp_sum) begin errors++; $display("FAIL bp_sum: got %h want %h", sum, exp_sum); end
        if (req_ready !== 1'b1) begin errors++; $display("FAIL bp_req_ready: got %b want 1", req_ready); end
    endtask

    task automatic test_back_to_back;
        int c0, c1;
        out_ready = 0;
        send(19'h00140, 8'd2);
        c0 = cyc;
        send(19'h00260, 8'd2);
        c1 = cyc;
        checks++;
        if (c1 - c0 !== 2 * (W + 1) + 1) begin
            errors++;
            $display("FAIL b2b_gap: got %0d cycles want %0d", c1 - c0, 2 * (W + 1) + 1);
        end
        repeat (8) tick;
        checks += 4;
        if (busy !== 1'b0) begin errors++; $display("FAIL b2b_busy: got %b want 0", busy); end
        if (out_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid: got %b want 1", out_valid); end
        if (out_data !== 8'h40) begin errors++; $display("FAIL b2b_head: got %h want 40", out_data); end
        if (sum !== 16'h00C1) begin errors++; $display("FAIL b2b_sum: got %h want 00c1", sum); end
        out_ready = 1;
        wait_drain(100);
        checks++;
        if (q.size() != 0) begin errors++; $display("FAIL b2b_count: %0d bytes missing, want 0", q.size()); end
    endtask

    task automatic test_reset_mid;
        out_ready = 1;
        send(19'h03333, 8'd5);
        tick;
        tick;
        rst = 1;
        tick;
        q.delete();
        checks += 5;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_valid: got %b want 0", out_valid); end
        if (req_ready !== 1'b1) begin errors++; $display("FAIL rstmid_req_ready: got %b want 1", req_ready); end
        if (rom_addr !== 19'd0) begin errors++; $display("FAIL rstmid_addr: got %h want 0", rom_addr); end
        if (sum !== 16'd0) begin errors++; $display("FAIL rstmid_sum: got %h want 0", sum); end
        if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b want 0", busy); end
        rst = 0;
        for (int k = 0; k < 8; k++) begin
            tick;
            checks++;
            if (out_valid !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL rstmid_quiet: cycle %0d valid=%b busy=%b want 0 0", k, out_valid, busy);
            end
        end
    endtask

    task automatic test_random;
        int t;
        scramble = 1;
        rand_rdy = 1;
        for (int b = 0; b < 8; b++) begin
            t = 0;
            while (!req_ready && t < 3000) begin tick; t++; end
            if (b > 0) begin
                checks++;
                if (sum !== exp_sum) begin errors++; $display("FAIL rand_sum: burst %0d got %h want %h", b - 1, sum, exp_sum); end
            end
            send(19'($urandom), b == 3 ? 8'd0 : 8'($urandom_range(1, 20)));
        end
        t = 0;
        while (!req_ready && t < 3000) begin tick; t++; end
        checks++;
        if (sum !== exp_sum) begin errors++; $display("FAIL rand_sum: last burst got %h want %h", sum, exp_sum); end
        rand_rdy = 0;
        out_ready = 1;
        wait_drain(200);
        checks++;
        if (q.size() != 0) begin errors++; $display("FAIL rand_count: %0d bytes missing, want 0", q.size()); end
    endtask

    task automatic test_len0;
        int t = 0;
        scramble = 0;
        out_ready0 = 1;
        send0(19'h00000, 8'd0);
        while (!req_ready0 && t < 400) begin tick; t++; end
        checks += 2;
        if (t !== 256) begin errors++; $display("FAIL len0_cycles: got %0d want 256", t); end
        if (sum0 !== 16'h7F80) begin errors++; $display("FAIL len0_sum: got %h want 7f80", sum0); end
        wait_drain0(50);
        checks++;
        if (q0.size() != 0) begin errors++; $display("FAIL len0_count: %0d bytes missing, want 0", q0.size()); end
    endtask

    task automatic test_random0;
        int t;
        scramble = 1;
        rand_rdy0 = 1;
        for (int b = 0; b < 8; b++) begin
            t = 0;
            while (!req_ready0 && t < 3000) begin tick; t++; end
            if (b > 0) begin
                checks++;
                if (sum0 !== exp_sum0) begin errors++; $display("FAIL rand0_sum: burst %0d got %h want %h", b - 1, sum0, exp_sum0); end
            end
            send0(19'($urandom), 8'($urandom_range(1, 16)));
        end
        t = 0;
        while (!req_ready0 && t < 3000) begin tick; t++; end
        checks++;
        if (sum0 !== exp_sum0) begin errors++; $display("FAIL rand0_sum: last burst got %h want %h", sum0, exp_sum0); end
        rand_rdy0 = 0;
        out_ready0 = 1;
        wait_drain0(200);
        checks++;
        if (q0.size() != 0) begin errors++; $display("FAIL rand0_count: %0d bytes missing, want 0", q0.size()); end
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset;
        test_basic;
        test_wrap;
        test_backpressure;
        test_back_to_back;
        test_reset_mid;
        test_random;
        test_len0;
        test_random0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
